grid_scan: RTL and testbench

GRID_SCAN -- requirements
Module: grid_scan

---
 rtl/grid_scan_pkg.sv | 25 ++
 rtl/grid_scan_timer.sv | 27 ++
 rtl/grid_scan.sv | 119 +++++++++++
 tb/tb_grid_scan.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_scan_pkg.sv
// Shared types and constants for the 8x8 row-scanned grid driver.
package grid_scan_pkg;

    localparam int unsigned GRID_W = 64;
    localparam int unsigned ROW_W  = 8;
    localparam int unsigned ROW_CW = $clog2(ROW_W);
    localparam int unsigned IDX_W  = $clog2(GRID_W);
    localparam int unsigned TMR_W  = 16;

    // Literals carry an ST_ prefix so they cannot collide with the GAP parameter.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Byte for row r: row 0 occupies the top byte of the frame.
    function automatic logic [ROW_W-1:0] row_byte(input logic [GRID_W-1:0] f,
                                                  input logic [ROW_CW-1:0] r);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(GRID_W - 1) - {r, 3'b000};
        return f[idx -: ROW_W];
    endfunction

endpackage

// File: rtl/grid_scan_timer.sv
// Loadable down-counter; terminal count while the count sits at zero.
module scan_timer
    import grid_scan_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_value,
    output logic             o_tc
);

    logic [TMR_W-1:0] r_count;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/grid_scan.sv
// Row-scanned 8x8 grid driver with double-buffered frames and blanking gaps.
module grid_scan
    import grid_scan_pkg::*;
#(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned GAP   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] frame_in,
    input  logic              frame_valid,
    output logic              frame_ready,
    output logic [ROW_W-1:0]  row_sel,
    output logic [ROW_W-1:0]  col_data,
    output logic              frame_done
);

    // Timer is loaded with length-1 so each phase spans exactly its length.
    localparam logic [TMR_W-1:0] DWELL_LD = TMR_W'(DWELL - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ROW_CW-1:0]   r_row;
    logic [GRID_W-1:0]   r_active;
    logic [GRID_W-1:0]   r_pending;
    logic                r_pend_full;

    logic                w_accept;
    logic                w_tc;
    logic                w_load;
    logic [TMR_W-1:0]    w_ld_val;
    logic                w_boundary;

    assign w_accept   = frame_valid && frame_ready;
    assign w_boundary = (r_state == ST_GAP) && (r_row == ROW_CW'(ROW_W - 1)) && w_tc;

    scan_timer u_timer (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_load),
        .i_value (w_ld_val),
        .o_tc    (w_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and timer reload decode.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_ld_val = DWELL_LD;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_SCAN;
                    w_load = 1'b1;
                end
            end
            ST_SCAN: begin
                if (w_tc) begin
                    w_next   = ST_GAP;
                    w_load   = 1'b1;
                    w_ld_val = GAP_LD;
                end
            end
            ST_GAP: begin
                if (w_tc) begin
                    w_next = ST_SCAN;
                    w_load = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Frame buffers and row counter; the active buffer only changes at the row-7 boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row       <= '0;
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_accept) begin
                    r_active <= frame_in;
                    r_row    <= '0;
                end
            end else begin
                if (r_state == ST_GAP && w_tc) begin
                    r_row <= r_row + 1'b1;
                end
                // Accept implies the pending slot was empty, so it never races the swap.
                if (w_boundary && r_pend_full) begin
                    r_active    <= r_pending;
                    r_pend_full <= 1'b0;
                end
                if (w_accept) begin
                    r_pending   <= frame_in;
                    r_pend_full <= 1'b1;
                end
            end
        end
    end

    assign frame_ready = (r_state == ST_IDLE) || !r_pend_full;
    assign row_sel     = (r_state == ST_SCAN) ? (ROW_W'(1) << r_row) : '0;
    assign col_data    = (r_state == ST_SCAN) ? row_byte(r_active, r_row) : '0;
    assign frame_done  = w_boundary;

endmodule

// File: tb/tb_grid_scan.sv
// Directed bench for grid_scan with DWELL=4, GAP=2 (48-cycle frame period).
module tb_grid_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] frame_in = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grid_scan #(.DWELL(4), .GAP(2)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_done  (frame_done)
    );

    // Cycle k counts periods after the load edge (k=1 is the first scan cycle).
    function automatic logic [7:0] exp_row(input int k);
        int p;
        p = (k - 1) % 48;
        if ((p % 6) >= 4) return 8'h00;
        return 8'(1 << (p / 6));
    endfunction

    function automatic logic [7:0] exp_col(input logic [63:0] f, input int k);
        int p;
        int r;
        p = (k - 1) % 48;
        r = p / 6;
        if ((p % 6) >= 4) return 8'h00;
        return f[63 - 8*r -: 8];
    endfunction

    task automatic do_reset();
        frame_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (row_sel !== 8'h00 || col_data !== 8'h00 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs row_sel=%h col_data=%h done=%b required 00/00/0", row_sel, col_data, frame_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_ready !== 1'b1 || row_sel !== 8'h00) begin
            failures++;
            $display("FAIL reset_idle ready=%b row_sel=%h required 1/00", frame_ready, row_sel);
        end
    endtask

    task automatic test_first_frame();
        logic [63:0] f;
        f = 64'h1E00_0000_0000_0000;
        do_reset();
        frame_in = f;
        frame_valid = 1'b1;
        checks++;
        if (frame_ready !== 1'b1) begin
            failures++;
            $display("FAIL first_ready got=%b required=1", frame_ready);
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            frame_valid = 1'b0;
            checks++;
            if (row_sel !== exp_row(k) || col_data !== exp_col(f, k)) begin
                failures++;
                $display("FAIL first_frame k=%0d row_sel=%h col=%h required %h/%h", k, row_sel, col_data, exp_row(k), exp_col(f, k));
            end
        end
    endtask

    task automatic test_pending();
        logic [63:0] fa, fb, fc, fe;
        logic        er;
        fa = 64'h0102_0408_1020_4080;
        fb = 64'hA5A5_5A5A_C3C3_3C3C;
        fc = 64'h1122_3344_5566_7788;
        do_reset();
        frame_in = fa;
        frame_valid = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            fe = (k <= 48) ? fa : (k <= 96) ? fb : fc;
            er = (k <= 10) || (k == 49) || (k >= 97);
            checks++;
            if (row_sel !== exp_row(k) || col_data !== exp_col(fe, k)) begin
                failures++;
                $display("FAIL pending_data k=%0d row_sel=%h col=%h required %h/%h", k, row_sel, col_data, exp_row(k), exp_col(fe, k));
            end
            checks++;
            if (frame_ready !== er) begin
                failures++;
                $display("FAIL pending_ready k=%0d got=%b required=%b", k, frame_ready, er);
            end
            checks++;
            if (frame_done !== ((k % 48) == 0)) begin
                failures++;
                $display("FAIL pending_done k=%0d got=%b required=%b", k, frame_done, (k % 48) == 0);
            end
            frame_valid = 1'b0;
            if (k == 10) begin
                frame_in = fb;
                frame_valid = 1'b1;
            end else if (k >= 11 && k <= 49) begin
                frame_in = fc;
                frame_valid = 1'b1;
            end
        end
    endtask

    task automatic test_rescan();
        logic [63:0] fa;
        fa = 64'hDEAD_BEEF_0123_4567;
        do_reset();
        frame_in = fa;
        frame_valid = 1'b1;
        for (int k = 1; k <= 96; k++) begin
            @(negedge clk);
            frame_valid = 1'b0;
            checks++;
            if (row_sel !== exp_row(k) || col_data !== exp_col(fa, k) || frame_done !== ((k % 48) == 0)) begin
                failures++;
                $display("FAIL rescan k=%0d row_sel=%h col=%h done=%b required %h/%h/%b", k, row_sel, col_data, frame_done, exp_row(k), exp_col(fa, k), (k % 48) == 0);
            end
        end
    endtask

    task automatic test_boundary();
        logic [63:0] fa, fd, fe;
        fa = 64'hF0E1_D2C3_B4A5_9687;
        fd = 64'h0F1E_2D3C_4B5A_6978;
        do_reset();
        frame_in = fa;
        frame_valid = 1'b1;
        for (int k = 1; k <= 104; k++) begin
            @(negedge clk);
            fe = (k <= 96) ? fa : fd;
            checks++;
            if (row_sel !== exp_row(k) || col_data !== exp_col(fe, k)) begin
                failures++;
                $display("FAIL boundary_data k=%0d row_sel=%h col=%h required %h/%h", k, row_sel, col_data, exp_row(k), exp_col(fe, k));
            end
            frame_valid = 1'b0;
            if (k == 48) begin
                checks++;
                if (frame_ready !== 1'b1 || frame_done !== 1'b1) begin
                    failures++;
                    $display("FAIL boundary_edge ready=%b done=%b required 1/1", frame_ready, frame_done);
                end
                frame_in = fd;
                frame_valid = 1'b1;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] fa;
        fa = 64'h8142_2418_1824_4281;
        do_reset();
        frame_in = fa;
        frame_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            frame_valid = 1'b0;
        end
        checks++;
        if (row_sel !== 8'h01 || col_data !== 8'h81) begin
            failures++;
            $display("FAIL async_pre row_sel=%h col=%h required 01/81", row_sel, col_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (row_sel !== 8'h00 || col_data !== 8'h00 || frame_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_scan row_sel=%h col=%h ready=%b required 00/00/1", row_sel, col_data, frame_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame_in = fa;
        frame_valid = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            frame_valid = 1'b0;
        end
        checks++;
        if (row_sel !== 8'h00 || frame_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_gap_pre row_sel=%h ready=%b required 00/1", row_sel, frame_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (row_sel !== 8'h00 || col_data !== 8'h00 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL async_gap row_sel=%h col=%h done=%b required 00/00/0", row_sel, col_data, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (row_sel !== 8'h00 || col_data !== 8'h00 || frame_ready !== 1'b1) begin
                failures++;
                $display("FAIL async_post k=%0d row_sel=%h col=%h ready=%b required 00/00/1", k, row_sel, col_data, frame_ready);
            end
        end
    endtask

    task automatic test_all_on();
        logic [63:0] f;
        f = 64'hFFFF_FFFF_FFFF_FFFF;
        do_reset();
        frame_in = f;
        frame_valid = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            frame_valid = 1'b0;
            checks++;
            if (row_sel !== exp_row(k) || col_data !== exp_col(f, k) || $countones(row_sel) > 1) begin
                failures++;
                $display("FAIL all_on k=%0d row_sel=%h col=%h required %h/%h", k, row_sel, col_data, exp_row(k), exp_col(f, k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_pending();
        test_rescan();
        test_boundary();
        test_async_reset();
        test_all_on();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
